// File: rtl/unified_mem_arbiter.sv
// Arbitrates a single-port RAM between fetch (read-only) and memory-stage (LW/SW) requesters.
// Reads take LAT+2 cycles and writes 3 cycles from request to ready; requesters hold their request and stall until ready.
module unified_mem_arbiter #(
  parameter int AW  = 8,
  parameter int DW  = 16,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ready,
  output logic [DW-1:0] if_rdata,
  input  logic          mem_rd,
  input  logic          mem_wr,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic          mem_ready,
  output logic [DW-1:0] mem_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          stall
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic GNT_IF  = 1'b0;
  localparam logic GNT_MEM = 1'b1;

  localparam logic [2:0] CNT_INIT = 3'(LAT - 1);

  logic [1:0]    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          gnt_q, gnt_d;
  logic          wr_q, wr_d;
  logic          last_grant_q, last_grant_d;
  logic          if_ready_q, if_ready_d;
  logic          mem_ready_q, mem_ready_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] mem_rdata_q, mem_rdata_d;
  logic          ram_en_q, ram_en_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;

  logic if_pend;
  logic mem_pend;
  logic pick_mem;

  // A port whose ready is pulsing has just been served and must not be re-granted this cycle.
  assign if_pend  = if_req & ~if_ready_q;
  assign mem_pend = (mem_rd | mem_wr) & ~mem_ready_q;
  assign pick_mem = mem_pend & (~if_pend | (last_grant_q != GNT_MEM));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gnt_d        = gnt_q;
    wr_d         = wr_q;
    last_grant_d = last_grant_q;
    if_ready_d   = 1'b0;
    mem_ready_d  = 1'b0;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    ram_en_d     = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (if_pend | mem_pend) begin
          // Write wins over read when the memory stage raises both.
          gnt_d       = pick_mem;
          wr_d        = pick_mem & mem_wr;
          ram_en_d    = 1'b1;
          ram_we_d    = pick_mem & mem_wr;
          ram_addr_d  = pick_mem ? mem_addr : if_addr;
          ram_wdata_d = pick_mem ? mem_wdata : ram_wdata_q;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d = CNT_INIT;
        if (wr_q || (LAT == 1)) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (!wr_q) begin
          if (gnt_q == GNT_MEM) begin
            mem_rdata_d = ram_rdata;
          end else begin
            if_rdata_d = ram_rdata;
          end
        end
        if (gnt_q == GNT_MEM) begin
          mem_ready_d = 1'b1;
        end else begin
          if_ready_d = 1'b1;
        end
        last_grant_d = gnt_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      gnt_q        <= GNT_IF;
      wr_q         <= 1'b0;
      last_grant_q <= GNT_IF;
      if_ready_q   <= 1'b0;
      mem_ready_q  <= 1'b0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      wr_q         <= wr_d;
      last_grant_q <= last_grant_d;
      if_ready_q   <= if_ready_d;
      mem_ready_q  <= mem_ready_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
    end
  end

  assign if_ready  = if_ready_q;
  assign if_rdata  = if_rdata_q;
  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

  assign stall = (if_req & ~if_ready_q) | ((mem_rd | mem_wr) & ~mem_ready_q);

endmodule
